// File: rtl/pspwm_pkg.sv
// Shared definitions for the phase-shift PWM AXI4-Lite register file:
// register byte offsets, AXI response codes, FSM state encodings and the
// address decode helper used by both the read and write channels.
package pspwm_pkg;

    localparam logic [4:0] REG_CTRL     = 5'h00;
    localparam logic [4:0] REG_PERIOD   = 5'h04;
    localparam logic [4:0] REG_PHASE    = 5'h08;
    localparam logic [4:0] REG_DEADTIME = 5'h0C;
    localparam logic [4:0] REG_STATUS   = 5'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACCEPT,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACCEPT,
        R_DATA
    } rd_state_e;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_PERIOD,
        SEL_PHASE,
        SEL_DEADTIME,
        SEL_STATUS,
        SEL_NONE
    } reg_sel_e;

    // Word-aligned decode: the two byte-offset bits are forced to zero so
    // unaligned addresses hit the word that contains them.
    function automatic reg_sel_e decode_addr(input logic [4:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        case ({addr[4:2], 2'b00})
            REG_CTRL:     sel = SEL_CTRL;
            REG_PERIOD:   sel = SEL_PERIOD;
            REG_PHASE:    sel = SEL_PHASE;
            REG_DEADTIME: sel = SEL_DEADTIME;
            REG_STATUS:   sel = SEL_STATUS;
            default:      sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pspwm_axil_strb_merge.sv
// Byte-lane merge for one register word.
// Ports:
//   old_i    - current register contents
//   new_i    - incoming write data
//   strb_i   - byte enables, one per lane of new_i
//   merged_o - old_i with every enabled lane replaced by the new_i lane
module pspwm_axil_strb_merge #(
    parameter int W = 32
) (
    input  logic [W-1:0]   old_i,
    input  logic [W-1:0]   new_i,
    input  logic [W/8-1:0] strb_i,
    output logic [W-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int unsigned i = 0; i < W / 8; i++) begin
            if (strb_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/pspwm_axil_regs.sv
// AXI4-Lite slave register file for the phase-shift PWM IP.
// Four RW configuration words (CTRL, PERIOD, PHASE, DEADTIME) drive the PWM
// core directly; STATUS at 0x10 reflects core_status. Unmapped slots answer
// SLVERR. Each channel carries one outstanding transaction and runs a
// three-state FSM (idle -> accept -> response/data).
// Ports:
//   ACLK, ARESET         - clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* - write address / data channel
//   S_AXI_B*             - write response channel
//   S_AXI_AR* / S_AXI_R* - read address / data channel
//   cfg_*                - register contents to the PWM core
//   cfg_commit           - one-cycle pulse after a configuration write lands
//   core_status          - core status word, readable at 0x10
// Only a 32-bit data bus and a 5-bit address are supported.
module pspwm_axil_regs
    import pspwm_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] DEFAULT_PERIOD = 32'h0000_0000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_ctrl,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_period,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_phase,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_deadtime,
    output logic                            cfg_commit,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_status
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    wr_state_e wstate_q, wstate_d;
    rd_state_e rstate_q, rstate_d;

    logic [DW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] period_q, period_d;
    logic [DW-1:0] phase_q, phase_d;
    logic [DW-1:0] deadtime_q, deadtime_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          commit_q, commit_d;

    logic [DW-1:0] ctrl_m, period_m, phase_m, deadtime_m;

    reg_sel_e wr_sel, rd_sel;

    // Protection bits and byte-offset bits carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_sel = decode_addr(S_AXI_AWADDR[4:0]);
    assign rd_sel = decode_addr(S_AXI_ARADDR[4:0]);

    // Byte-lane merges, one per RW register

    pspwm_axil_strb_merge #(.W(DW)) u_merge_ctrl (
        .old_i    (ctrl_q),
        .new_i    (S_AXI_WDATA),
        .strb_i   (S_AXI_WSTRB),
        .merged_o (ctrl_m)
    );

    pspwm_axil_strb_merge #(.W(DW)) u_merge_period (
        .old_i    (period_q),
        .new_i    (S_AXI_WDATA),
        .strb_i   (S_AXI_WSTRB),
        .merged_o (period_m)
    );

    pspwm_axil_strb_merge #(.W(DW)) u_merge_phase (
        .old_i    (phase_q),
        .new_i    (S_AXI_WDATA),
        .strb_i   (S_AXI_WSTRB),
        .merged_o (phase_m)
    );

    pspwm_axil_strb_merge #(.W(DW)) u_merge_deadtime (
        .old_i    (deadtime_q),
        .new_i    (S_AXI_WDATA),
        .strb_i   (S_AXI_WSTRB),
        .merged_o (deadtime_m)
    );

    // Write channel FSM

    always_comb begin
        wstate_d      = wstate_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wstate_d = W_ACCEPT;
                end
            end
            W_ACCEPT: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                wstate_d      = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Register update happens on the AW/W handshake edge (end of W_ACCEPT),
    // so the response and commit pulse appear together in the next cycle.
    always_comb begin
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        phase_d    = phase_q;
        deadtime_d = deadtime_q;
        bresp_d    = bresp_q;
        commit_d   = 1'b0;
        if (wstate_q == W_ACCEPT) begin
            bresp_d = RESP_OKAY;
            case (wr_sel)
                SEL_CTRL: begin
                    ctrl_d   = ctrl_m;
                    commit_d = 1'b1;
                end
                SEL_PERIOD: begin
                    period_d = period_m;
                    commit_d = 1'b1;
                end
                SEL_PHASE: begin
                    phase_d  = phase_m;
                    commit_d = 1'b1;
                end
                SEL_DEADTIME: begin
                    deadtime_d = deadtime_m;
                    commit_d   = 1'b1;
                end
                SEL_STATUS: begin
                    bresp_d = RESP_OKAY;
                end
                default: begin
                    bresp_d = RESP_SLVERR;
                end
            endcase
        end
    end

    // Read channel FSM

    always_comb begin
        rstate_d      = rstate_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rstate_d = R_ACCEPT;
                end
            end
            R_ACCEPT: begin
                S_AXI_ARREADY = 1'b1;
                rstate_d      = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read data is captured from the *_q registers on the AR handshake edge,
    // so a write landing on that same edge is not visible to this read.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (rstate_q == R_ACCEPT) begin
            rresp_d = RESP_OKAY;
            case (rd_sel)
                SEL_CTRL:     rdata_d = ctrl_q;
                SEL_PERIOD:   rdata_d = period_q;
                SEL_PHASE:    rdata_d = phase_q;
                SEL_DEADTIME: rdata_d = deadtime_q;
                SEL_STATUS:   rdata_d = core_status;
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            ctrl_q     <= '0;
            period_q   <= DEFAULT_PERIOD;
            phase_q    <= '0;
            deadtime_q <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            commit_q   <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            phase_q    <= phase_d;
            deadtime_q <= deadtime_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            commit_q   <= commit_d;
        end
    end

    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign cfg_ctrl     = ctrl_q;
    assign cfg_period   = period_q;
    assign cfg_phase    = phase_q;
    assign cfg_deadtime = deadtime_q;
    assign cfg_commit   = commit_q;

endmodule
